// File: rtl/frame_feeder.sv
// frame_feeder: pixel store and raster scanner feeding a 32x32 RGB matrix driver.
// Each cycle presents one upper-half / lower-half pixel pair, one cycle behind the scan counter.
// Build option FRAME_DOUBLE_BUFFER_EN: two buffers (display + back) with a swap that is
// requested by donesending and deferred to the frame boundary. Without it, a single buffer
// is both written and displayed, and donesending is ignored.
module frame_feeder (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [9:0] wr_addr,
    input  logic [2:0] wr_data,
    input  logic       donesending,
    output logic [2:0] RGB1bus,
    output logic [2:0] RGB2bus,
    output logic [4:0] col,
    output logic [3:0] row,
    output logic       frame_start,
    output logic       swap_pending
);

    // Scan position {row[3:0], col[4:0]} of the pixel pair being read this cycle.
    logic [8:0] scan_q;
    logic [8:0] scan_d;

    // Registered outputs, one cycle behind scan_q.
    logic [2:0] rgb1_q;
    logic [2:0] rgb2_q;
    logic [4:0] col_q;
    logic [3:0] row_q;
    logic       fs_q;

    // Display-buffer read data for the current scan position.
    logic [2:0] pix_up;
    logic [2:0] pix_dn;

    logic       boundary;

    assign scan_d   = scan_q + 9'd1;
    assign boundary = (scan_q == 9'd511);

`ifdef FRAME_DOUBLE_BUFFER_EN

    typedef enum logic [0:0] {
        StIdle,
        StPend
    } swap_state_e;

    logic [2:0]  buf_a [0:1023];
    logic [2:0]  buf_b [0:1023];
    swap_state_e state_q;
    logic        disp_sel_q;

    // Writes land in whichever buffer is not displayed; on a swap edge that is the old back
    // buffer, which is exactly the one becoming visible.
    always_ff @(posedge clk) begin
        if (reset && wr_en) begin
            if (disp_sel_q) begin
                buf_a[wr_addr] <= wr_data;
            end else begin
                buf_b[wr_addr] <= wr_data;
            end
        end
    end

    // Read both halves of the display buffer at the current scan position.
    always_comb begin
        pix_up = buf_a[{1'b0, scan_q}];
        pix_dn = buf_a[{1'b1, scan_q}];
        if (disp_sel_q) begin
            pix_up = buf_b[{1'b0, scan_q}];
            pix_dn = buf_b[{1'b1, scan_q}];
        end
    end

    // Swap FSM: a request waits in StPend until the last pixel of the frame is read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            disp_sel_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (donesending) begin
                        // A request landing on the boundary swaps at once.
                        if (boundary) begin
                            disp_sel_q <= ~disp_sel_q;
                        end else begin
                            state_q <= StPend;
                        end
                    end
                end
                StPend: begin
                    // Further requests are absorbed here: one swap per frame at most.
                    if (boundary) begin
                        disp_sel_q <= ~disp_sel_q;
                        state_q    <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign swap_pending = (state_q == StPend);

`else

    logic [2:0] buf_s [0:1023];
    logic       unused_donesending;

    // Single shared buffer: writes become visible on the next read of that address.
    always_ff @(posedge clk) begin
        if (reset && wr_en) begin
            buf_s[wr_addr] <= wr_data;
        end
    end

    // Read both halves of the shared buffer at the current scan position.
    always_comb begin
        pix_up = buf_s[{1'b0, scan_q}];
        pix_dn = buf_s[{1'b1, scan_q}];
    end

    assign unused_donesending = donesending;
    assign swap_pending       = 1'b0;

`endif

    // Free-running scan counter and the one-cycle output pipeline stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scan_q <= 9'd0;
            rgb1_q <= 3'd0;
            rgb2_q <= 3'd0;
            col_q  <= 5'd0;
            row_q  <= 4'd0;
            fs_q   <= 1'b0;
        end else begin
            scan_q <= scan_d;
            rgb1_q <= pix_up;
            rgb2_q <= pix_dn;
            col_q  <= scan_q[4:0];
            row_q  <= scan_q[8:5];
            fs_q   <= (scan_q == 9'd0);
        end
    end

    assign RGB1bus     = rgb1_q;
    assign RGB2bus     = rgb2_q;
    assign col         = col_q;
    assign row         = row_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_frame_feeder.sv
// Self-checking bench for frame_feeder. A cycle model predicts every output word; it is queued
// when the edge's stimulus is driven and compared after the edge. Directed checks cover reset,
// frame timing and the swap corner cases. Works with or without FRAME_DOUBLE_BUFFER_EN.
module tb_frame_feeder;

`ifdef FRAME_DOUBLE_BUFFER_EN
    localparam bit DB = 1'b1;
`else
    localparam bit DB = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [9:0] wr_addr;
    logic [2:0] wr_data;
    logic       donesending;
    logic [2:0] RGB1bus;
    logic [2:0] RGB2bus;
    logic [4:0] col;
    logic [3:0] row;
    logic       frame_start;
    logic       swap_pending;

    frame_feeder u_dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .donesending  (donesending),
        .RGB1bus      (RGB1bus),
        .RGB2bus      (RGB2bus),
        .col          (col),
        .row          (row),
        .frame_start  (frame_start),
        .swap_pending (swap_pending)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [16:0] val;
        logic [16:0] mask;
    } sb_t;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [8:0] m_scan;
    logic       m_sel;
    logic       m_pend;
    logic [2:0] m_mem   [0:1][0:1023];
    bit         m_known [0:1][0:1023];
    sb_t        sb_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Predict the output word produced by the coming edge and update the model state.
    task automatic model_edge();
        sb_t  e;
        logic dsel;
        logic wsel;
        if (!reset) begin
            m_scan = 9'd0;
            m_sel  = 1'b0;
            m_pend = 1'b0;
            e.val  = '0;
            e.mask = '1;
        end else begin
            dsel   = DB ? m_sel : 1'b0;
            wsel   = DB ? ~m_sel : 1'b0;
            e.val  = {m_mem[dsel][{1'b0, m_scan}], m_mem[dsel][{1'b1, m_scan}],
                      m_scan[4:0], m_scan[8:5], (m_scan == 9'd0), 1'b0};
            e.mask = {{3{m_known[dsel][{1'b0, m_scan}]}}, {3{m_known[dsel][{1'b1, m_scan}]}},
                      11'h7ff};
            if (wr_en) begin
                m_mem[wsel][wr_addr]   = wr_data;
                m_known[wsel][wr_addr] = 1'b1;
            end
            if (DB) begin
                if (m_scan == 9'd511 && (m_pend || donesending)) begin
                    m_sel  = ~m_sel;
                    m_pend = 1'b0;
                end else if (donesending) begin
                    m_pend = 1'b1;
                end
            end
            m_scan = m_scan + 9'd1;
            e.val[0] = m_pend;
        end
        sb_q.push_back(e);
    endtask

    // Drive one cycle of stimulus, advance one edge, then score the DUT output word.
    task automatic cycle(input logic we, input logic [9:0] a, input logic [2:0] d,
                         input logic ds);
        sb_t         e;
        logic [16:0] got;
        wr_en       = we;
        wr_addr     = a;
        wr_data     = d;
        donesending = ds;
        model_edge();
        @(posedge clk);
        #1;
        e   = sb_q.pop_front();
        got = {RGB1bus, RGB2bus, col, row, frame_start, swap_pending};
        check_eq("scan_word", 32'(got & e.mask), 32'(e.val & e.mask));
        wr_en       = 1'b0;
        donesending = 1'b0;
    endtask

    task automatic idle();
        cycle(1'b0, 10'd0, 3'd0, 1'b0);
    endtask

    // Run until the DUT shows frame_start; n returns the number of edges taken.
    task automatic wait_fs(output int n);
        n = 0;
        do begin
            idle();
            n++;
        end while (!frame_start && n < 1100);
        if (!frame_start) check_eq("wait_fs_timeout", 32'(frame_start), 32'd1);
    endtask

    // Advance until the scan counter (as tracked by the model) equals target.
    task automatic goto_scan(input logic [8:0] target);
        int guard = 0;
        while (m_scan != target && guard < 600) begin
            idle();
            guard++;
        end
    endtask

    function automatic logic [2:0] pat1(input int i);
        logic [9:0] a = 10'(i);
        return a[2:0] ^ a[7:5] ^ {2'b0, a[9]};
    endfunction

    function automatic logic [2:0] pat2(input int i);
        if (i == 0 || i == 32'h200) return 3'd0;
        return 3'(i * 5 + 3);
    endfunction

    int n;

    initial begin
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < 1024; i++) m_known[b][i] = 1'b0;
        reset       = 1'b0;
        wr_en       = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        donesending = 1'b0;
        m_scan      = '0;
        m_sel       = 1'b0;
        m_pend      = 1'b0;

        // Writes and swap requests while in reset must be ignored.
        repeat (3) cycle(1'b1, 10'h005, 3'b111, 1'b1);
        check_eq("rst_rgb", 32'({RGB1bus, RGB2bus}), 32'd0);
        check_eq("rst_pos", 32'({row, col}), 32'd0);
        check_eq("rst_fs", 32'(frame_start), 32'd0);
        check_eq("rst_sp", 32'(swap_pending), 32'd0);

        // Fill the back (or only) buffer, swap, then fill the other one.
        reset = 1'b1;
        for (int i = 0; i < 1024; i++) cycle(1'b1, 10'(i), pat1(i), 1'b0);
        cycle(1'b0, 10'd0, 3'd0, 1'b1);
        repeat (512) idle();
        for (int i = 0; i < 1024; i++) cycle(1'b1, 10'(i), pat2(i), 1'b0);

        // Reset for 3 cycles; first edge after release presents (0,0) from A.
        reset = 1'b0;
        repeat (3) idle();
        reset = 1'b1;
        idle();
        check_eq("first_fs", 32'(frame_start), 32'd1);
        check_eq("first_pos", 32'({row, col}), 32'd0);
        check_eq("first_rgb", 32'({RGB1bus, RGB2bus}), 32'd0);
        wait_fs(n);
        check_eq("fs_period", 32'(n), 32'd512);

        // Write corner pixels into the back buffer, then request a swap.
        cycle(1'b1, 10'h000, 3'b100, 1'b0);
        cycle(1'b1, 10'h200, 3'b001, 1'b0);
        cycle(1'b0, 10'd0, 3'd0, 1'b1);
        wait_fs(n);
        check_eq("swap_rgb1", 32'(RGB1bus), 32'(3'b100));
        check_eq("swap_rgb2", 32'(RGB2bus), 32'(3'b001));

        // Request at count 100 is held until the boundary edge.
        goto_scan(9'd100);
        cycle(1'b0, 10'd0, 3'd0, 1'b1);
        check_eq("pend_set", 32'(swap_pending), 32'(DB));
        goto_scan(9'd511);
        check_eq("pend_hold", 32'(swap_pending), 32'(DB));
        idle();
        check_eq("pend_clear", 32'(swap_pending), 32'd0);
        idle();
        check_eq("new_buf_rgb1", 32'(RGB1bus), DB ? 32'd0 : 32'(3'b100));
        check_eq("new_buf_rgb2", 32'(RGB2bus), DB ? 32'd0 : 32'(3'b001));

        // Request exactly at count 511 swaps on that edge without pending.
        goto_scan(9'd511);
        cycle(1'b0, 10'd0, 3'd0, 1'b1);
        check_eq("imm_sp", 32'(swap_pending), 32'd0);
        idle();
        check_eq("imm_rgb1", 32'(RGB1bus), 32'(3'b100));

        // Two requests in one frame give a single toggle.
        goto_scan(9'd50);
        cycle(1'b0, 10'd0, 3'd0, 1'b1);
        goto_scan(9'd200);
        cycle(1'b0, 10'd0, 3'd0, 1'b1);
        check_eq("dbl_sp", 32'(swap_pending), 32'(DB));
        wait_fs(n);
        check_eq("one_toggle", 32'(RGB1bus), DB ? 32'd0 : 32'(3'b100));

        // Reset while pending discards the request.
        goto_scan(9'd100);
        cycle(1'b0, 10'd0, 3'd0, 1'b1);
        goto_scan(9'd300);
        reset = 1'b0;
        #1;
        check_eq("mid_rst_sp", 32'(swap_pending), 32'd0);
        check_eq("mid_rst_pos", 32'({row, col}), 32'd0);
        check_eq("mid_rst_fs", 32'(frame_start), 32'd0);
        repeat (2) idle();
        reset = 1'b1;
        idle();
        wait_fs(n);
        check_eq("no_swap", 32'(RGB1bus), DB ? 32'd0 : 32'(3'b100));
        check_eq("no_swap_sp", 32'(swap_pending), 32'd0);

        // A write to 0x021 shows at row 1 / col 1 only when it hits the displayed buffer.
        cycle(1'b1, 10'h021, 3'b110, 1'b0);
        n = 0;
        do begin
            idle();
            n++;
        end while (!(row == 4'd1 && col == 5'd1) && n < 600);
        check_eq("pos_reached", 32'({row, col}), 32'({4'd1, 5'd1}));
        check_eq("wr_visible", 32'(RGB1bus), DB ? 32'(pat2(32'h021)) : 32'(3'b110));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
